// File: rtl/result_denormalizer_pkg.sv
`default_nettype none
//==============================================================================
// Module      : result_denormalizer_pkg
// Description : Shared constants, FSM state encoding and helpers for the
//               result denormalizer and the angle normalizer.
// Revision    : 1.0 - initial release
//==============================================================================
package result_denormalizer_pkg;

    // FSM state encoding (explicit 3-bit width)
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ROTATE = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_PACK   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Q2.14 representation of 1.0
    localparam int          Q14_ONE       = 16384;
    // IEEE 754 single-precision exponent bias
    localparam int          FP32_EXP_BIAS = 127;
    // IEEE 754 positive zero
    localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;

    // 16-bit two's complement negation; -(-32768) wraps to -32768
    function automatic logic [15:0] neg16(input logic [15:0] v);
        return (~v) + 16'd1;
    endfunction

endpackage : result_denormalizer_pkg
`default_nettype wire

// File: rtl/result_denormalizer_quadrant_rotator.sv
`default_nettype none
//==============================================================================
// Module      : quadrant_rotator
// Description : Combinational quadrant un-reduction. k = (-flip) mod 4 picks
//               one of four swap/negate mappings of the (sin, cos) pair.
//               With ENABLE = 0 the pair passes through unchanged.
// Revision    : 1.0 - initial release
//==============================================================================
module quadrant_rotator
    import result_denormalizer_pkg::*;
#(
    parameter bit ENABLE = 1'b1
) (
    input  logic [15:0] i_sin,
    input  logic [15:0] i_cos,
    input  logic [3:0]  i_flip,
    output logic [15:0] o_sin,
    output logic [15:0] o_cos
);

    logic [3:0] w_neg_flip;
    logic [1:0] w_k;
    logic       w_unused_flip_hi;

    // Only the low two bits of the negated count select the quadrant
    assign w_neg_flip       = (~i_flip) + 4'd1;
    assign w_k              = ENABLE ? w_neg_flip[1:0] : 2'd0;
    assign w_unused_flip_hi = ^w_neg_flip[3:2];

    // Quarter-turn mapping of the reduced-angle results
    always_comb begin
        o_sin = i_sin;
        o_cos = i_cos;
        case (w_k)
            2'd0: begin
                o_sin = i_sin;
                o_cos = i_cos;
            end
            2'd1: begin
                o_sin = i_cos;
                o_cos = neg16(i_sin);
            end
            2'd2: begin
                o_sin = neg16(i_sin);
                o_cos = neg16(i_cos);
            end
            default: begin
                o_sin = neg16(i_cos);
                o_cos = i_sin;
            end
        endcase
    end

endmodule : quadrant_rotator
`default_nettype wire

// File: rtl/result_denormalizer.sv
`default_nettype none
//==============================================================================
// Module      : result_denormalizer
// Description : Undoes the quadrant reduction on a Q2.14 sine/cosine pair and
//               converts both values to IEEE 754 single precision using one
//               shared shift-normalizer, sine first, then cosine.
//               Build option: RESULT_QUADRANT_EN enables the quadrant mapping;
//               without it flip is ignored (latency unchanged).
// Revision    : 1.0 - initial release
//==============================================================================
module result_denormalizer
    import result_denormalizer_pkg::*;
#(
    parameter int FRAC_BITS = $clog2(Q14_ONE),
    parameter int EXP_BIAS  = FP32_EXP_BIAS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] sin_in,
    input  logic [15:0] cos_in,
    input  logic [3:0]  flip,
    output logic [31:0] sin_out,
    output logic [31:0] cos_out,
    output logic        valid,
    output logic        busy
);

    // Exponent of a magnitude whose bit 15 is set, before any normalizing shift
    localparam int          c_exp_init_i = EXP_BIAS + 15 - FRAC_BITS;
    localparam logic [7:0]  c_exp_init   = c_exp_init_i[7:0];

`ifdef RESULT_QUADRANT_EN
    localparam bit          c_quad_en    = 1'b1;
`else
    localparam bit          c_quad_en    = 1'b0;
`endif

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_sin;
    logic [15:0] r_cos;
    logic [3:0]  r_flip;
    logic        r_sel;
    logic        r_sign;
    logic [15:0] r_mag;
    logic [7:0]  r_exp;
    logic        r_zero;
    logic [31:0] r_sin_out;
    logic [31:0] r_cos_out;
    logic        r_valid;
    logic        r_busy;

    logic [15:0] w_sin_rot;
    logic [15:0] w_cos_rot;
    logic [15:0] w_op;
    logic [31:0] w_word;

    assign sin_out = r_sin_out;
    assign cos_out = r_cos_out;
    assign valid   = r_valid;
    assign busy    = r_busy;

    // Operand currently being normalized: sine first, then cosine
    assign w_op   = r_sel ? r_cos : r_sin;
    // Packed float; a zero operand always packs as +0 regardless of sign
    assign w_word = r_zero ? FP32_ZERO : {r_sign, r_exp, r_mag[14:0], 8'h00};

    quadrant_rotator #(
        .ENABLE (c_quad_en)
    ) u_quadrant_rotator (
        .i_sin  (r_sin),
        .i_cos  (r_cos),
        .i_flip (r_flip),
        .o_sin  (w_sin_rot),
        .o_cos  (w_cos_rot)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   w_next = start ? ST_ROTATE : ST_IDLE;
            ST_ROTATE: w_next = ST_LOAD;
            ST_LOAD:   w_next = (w_op == 16'd0) ? ST_PACK : ST_SHIFT;
            ST_SHIFT:  w_next = r_mag[15] ? ST_PACK : ST_SHIFT;
            ST_PACK:   w_next = r_sel ? ST_DONE : ST_LOAD;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Datapath: capture, rotate, split, normalize, pack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sin     <= 16'd0;
            r_cos     <= 16'd0;
            r_flip    <= 4'd0;
            r_sel     <= 1'b0;
            r_sign    <= 1'b0;
            r_mag     <= 16'd0;
            r_exp     <= 8'd0;
            r_zero    <= 1'b0;
            r_sin_out <= FP32_ZERO;
            r_cos_out <= FP32_ZERO;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sin   <= sin_in;
                        r_cos   <= cos_in;
                        r_flip  <= flip;
                        r_valid <= 1'b0;
                    end
                end
                ST_ROTATE: begin
                    r_sin <= w_sin_rot;
                    r_cos <= w_cos_rot;
                    r_sel <= 1'b0;
                end
                ST_LOAD: begin
                    r_sign <= w_op[15];
                    r_mag  <= w_op[15] ? neg16(w_op) : w_op;
                    r_exp  <= c_exp_init;
                    r_zero <= (w_op == 16'd0);
                end
                ST_SHIFT: begin
                    if (!r_mag[15]) begin
                        r_mag <= {r_mag[14:0], 1'b0};
                        r_exp <= r_exp - 8'd1;
                    end
                end
                ST_PACK: begin
                    if (r_sel) begin
                        r_cos_out <= w_word;
                    end else begin
                        r_sin_out <= w_word;
                    end
                    r_sel <= 1'b1;
                end
                ST_DONE: begin
                    r_valid <= 1'b1;
                end
                default: begin
                    r_sel <= 1'b0;
                end
            endcase
        end
    end

    // Busy is registered and follows the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_next != ST_IDLE);
        end
    end

endmodule : result_denormalizer
`default_nettype wire

// File: tb/tb_result_denormalizer.sv
`default_nettype none
//==============================================================================
// Module      : tb_result_denormalizer
// Description : Self-checking bench for result_denormalizer. Expected floats
//               and latencies come from an arithmetic model of the sin/cos
//               quarter-turn identities and IEEE 754 encoding.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_result_denormalizer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] sin_in;
    logic [15:0] cos_in;
    logic [3:0]  flip;
    logic [31:0] sin_out;
    logic [31:0] cos_out;
    logic        valid;
    logic        busy;

    int total;
    int bad;

    result_denormalizer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sin_in  (sin_in),
        .cos_in  (cos_in),
        .flip    (flip),
        .sin_out (sin_out),
        .cos_out (cos_out),
        .valid   (valid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int wrap16(input int x);
        logic signed [15:0] t;
        t = 16'(x);
        return int'(t);
    endfunction

    function automatic int msb_index(input int m);
        int p;
        p = 0;
        for (int i = 0; i < 17; i++) if (m >= (1 << i)) p = i;
        return p;
    endfunction

    function automatic logic [31:0] fp32_of(input int v);
        int          m;
        int          p;
        logic [31:0] e;
        logic [31:0] frac;
        if (v == 0) return 32'h0;
        m    = (v < 0) ? -v : v;
        p    = msb_index(m);
        e    = 32'(127 + p - 14);
        frac = 32'(m << (23 - p)) & 32'h007F_FFFF;
        return {(v < 0), e[7:0], frac[22:0]};
    endfunction

    // cycles spent by one operand: LOAD + SHIFT(lz+1) + PACK, or LOAD + PACK
    function automatic int op_cycles(input int v);
        int m;
        if (v == 0) return 2;
        m = (v < 0) ? -v : v;
        return 3 + (15 - msb_index(m));
    endfunction

    // sin(x + k*90deg), cos(x + k*90deg) by repeated quarter turns
    task automatic model(input int s, input int c, input int f,
                         output int rs, output int rc);
        int k;
        int t;
        rs = s;
        rc = c;
`ifdef RESULT_QUADRANT_EN
        k = (((-f) % 4) + 4) % 4;
`else
        k = 0;
`endif
        for (int i = 0; i < k; i++) begin
            t  = rs;
            rs = rc;
            rc = wrap16(-t);
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request; it is sampled on the next rising edge
    task automatic launch(input int s, input int c, input int f);
        @(negedge clk);
        sin_in = 16'(s);
        cos_in = 16'(c);
        flip   = 4'(f);
        start  = 1'b1;
    endtask

    // Called #1 after the sampling edge (edge 1); waits for valid and checks
    task automatic wait_result(input int s, input int c, input int f,
                               input string tag, input bit poke);
        int rs, rc, n, exp_n;
        bit got;
        model(s, c, f, rs, rc);
        exp_n = 3 + op_cycles(rs) + op_cycles(rc);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_vclr"}, 32'(valid), 32'd0);
        n   = 1;
        got = 1'b0;
        while (n < 80 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (valid === 1'b1) got = 1'b1;
            if (poke && n == 4) begin
                start  = 1'b1;
                sin_in = ~sin_in;
                cos_in = 16'h1234;
            end
            if (poke && n == 5) start = 1'b0;
        end
        check({tag, "_got"}, 32'(got), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'(exp_n));
        check({tag, "_sin"}, sin_out, fp32_of(rs));
        check({tag, "_cos"}, cos_out, fp32_of(rc));
    endtask

    task automatic run_job(input int s, input int c, input int f,
                           input string tag, input bit poke);
        launch(s, c, f);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_result(s, c, f, tag, poke);
    endtask

    function automatic int rand16();
        int v;
        v = wrap16(int'($urandom));
        return v >>> $urandom_range(0, 15);
    endfunction

    // ---------------- directed / random sequence ----------------
    initial begin
        int s, c, f;
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        start  = 1'b0;
        sin_in = 16'd0;
        cos_in = 16'd0;
        flip   = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sin", sin_out, 32'h0);
        check("rst_cos", cos_out, 32'h0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);

        // plan vectors
        run_job(16384, 0, 0, "p1", 1'b0);
        check("p1_const", sin_out, 32'h3F80_0000);
        run_job(0, 16384, -1, "p2", 1'b0);
        run_job(8192, -16384, 2, "p3", 1'b0);
        run_job(1, -32768, 0, "p4", 1'b0);
        check("p4_const", cos_out, 32'hC000_0000);
        run_job(8192, 16384, 1, "p6", 1'b0);
        run_job(-32768, -32768, 3, "wrap", 1'b0);
        run_job(0, 0, 0, "zero", 1'b0);
        run_job(1, 1, 5, "tiny", 1'b0);

        // reset while the first operand is in SHIFT
        launch(1, 16384, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_sin", sin_out, 32'h0);
        check("mid_rst_cos", cos_out, 32'h0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_job(-12345, 321, 1, "after_rst", 1'b0);

        // start pulse while busy must be ignored
        run_job(4096, -2048, -2, "poke", 1'b1);

        // start held high: next job accepted right after DONE
        launch(3000, -700, 1);
        @(posedge clk);
        #1;
        wait_result(3000, -700, 1, "hold1", 1'b0);
        sin_in = 16'(-5);
        cos_in = 16'(9999);
        flip   = 4'(-3);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hold_vpulse", 32'(valid), 32'd0);
        wait_result(-5, 9999, -3, "hold2", 1'b0);

        // randomized jobs
        for (int j = 0; j < 25; j++) begin
            s = rand16();
            c = rand16();
            f = int'($urandom_range(0, 15)) - 8;
            run_job(s, c, f, "rnd", 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_result_denormalizer
`default_nettype wire
